// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
//   Recovers pixel coordinates and timing lock from a raw VGA sync stream.
//   sync_h, sync_v and blank_n are registered once (s_h, s_v, s_b) and again
//   (d_h, d_v, d_b) for edge detection. A falling s_h starts a line (LS) and
//   a falling s_v starts a frame (FS). Line and frame lengths are measured
//   against H_TOTAL / V_TOTAL. A three-state FSM (SEARCH, CHECK, LOCKED)
//   declares lock after LOCK_FRAMES consecutive good frames.
//
// Parameters
//   H_TOTAL      pixel clocks per line
//   V_TOTAL      lines per frame
//   LOCK_FRAMES  consecutive good frames needed to lock
//
// Ports
//   clk          pixel clock, one pixel per cycle
//   reset        asynchronous active-high reset
//   sync_h       horizontal sync, active low
//   sync_v       vertical sync, active low
//   blank_n      high during active video
//   col_o        active-pixel column (saturates at 1023)
//   row_o        active-line row (saturates at 1023)
//   pix_valid    col_o/row_o address a displayable pixel (s_b AND locked)
//   frame_start  one-cycle pulse on every FS
//   locked       timing matches H_TOTAL/V_TOTAL
//   err          one-cycle pulse when timing breaks while locked
//   err_cnt_o    saturating count of err pulses
//
// Build option
//   VGA_DEC_ERRCNT_EN  when defined, err_cnt_o counts err pulses (saturating
//                      at 255, cleared only by reset); otherwise it is tied 0.
module vga_sync_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sync_h,
  input  logic       sync_v,
  input  logic       blank_n,
  output logic [9:0] col_o,
  output logic [9:0] row_o,
  output logic       pix_valid,
  output logic       frame_start,
  output logic       locked,
  output logic       err,
  output logic [7:0] err_cnt_o
);

  localparam int CNT_W = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [11:0]      H_TOTAL_W = 12'(H_TOTAL);
  localparam logic [10:0]      V_TOTAL_W = 11'(V_TOTAL);
  localparam logic [CNT_W-1:0] LOCK_W    = CNT_W'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH,
    CHECK,
    LOCKED
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] good_cnt;
  logic [CNT_W-1:0] good_cnt_next;
  logic [CNT_W-1:0] good_cnt_inc;
  logic             bad_seen;
  logic             bad_seen_next;
  logic             err_int;

  logic s_h, s_v, s_b;
  logic d_h, d_v, d_b;
  logic ls, fs, b_fall;

  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic [9:0]  col_cnt;
  logic [9:0]  row_cnt;
  logic [11:0] line_len;
  logic [10:0] frame_len;
  logic        line_bad;
  logic        frame_ok;
  logic        h_sat;

  // Input registers and the delayed copies used for edge detection. Nothing
  // downstream ever looks at the raw pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_h <= 1'b0;
      s_v <= 1'b0;
      s_b <= 1'b0;
      d_h <= 1'b0;
      d_v <= 1'b0;
      d_b <= 1'b0;
    end else begin
      s_h <= sync_h;
      s_v <= sync_v;
      s_b <= blank_n;
      d_h <= s_h;
      d_v <= s_v;
      d_b <= s_b;
    end
  end

  assign ls     = d_h & ~s_h;
  assign fs     = d_v & ~s_v;
  assign b_fall = d_b & ~s_b;

  // A line/frame length is only meaningful in the cycle of its LS/FS. An LS
  // coinciding with FS belongs to the frame that FS terminates.
  assign line_len  = {1'b0, h_cnt} + 12'd1;
  assign line_bad  = ls && (line_len != H_TOTAL_W);
  assign frame_len = {1'b0, v_cnt} + {10'd0, ls};
  assign frame_ok  = (frame_len == V_TOTAL_W);
  assign h_sat     = (h_cnt == 11'h7FF);

  // Timing measurement counters: cycles since LS and lines since FS, both
  // saturating so a dead sync input cannot wrap them into a plausible value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      if (ls)
        h_cnt <= '0;
      else if (!h_sat)
        h_cnt <= h_cnt + 11'd1;

      if (fs)
        v_cnt <= '0;
      else if (ls && (v_cnt != 10'h3FF))
        v_cnt <= v_cnt + 10'd1;
    end
  end

  // Pixel address counters. Column advances on every active cycle and is
  // cleared at line start; row advances when active video ends for a line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else begin
      if (ls)
        col_cnt <= '0;
      else if (s_b && (col_cnt != 10'h3FF))
        col_cnt <= col_cnt + 10'd1;

      if (fs)
        row_cnt <= '0;
      else if (b_fall && (row_cnt != 10'h3FF))
        row_cnt <= row_cnt + 10'd1;
    end
  end

  // Output stage: the address of the pixel seen in s_b is presented together
  // with its valid flag one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_o     <= '0;
      row_o     <= '0;
      pix_valid <= 1'b0;
    end else begin
      col_o     <= col_cnt;
      row_o     <= row_cnt;
      pix_valid <= s_b && (state == LOCKED);
    end
  end

  // Lock FSM state register, good-frame counter and the "this frame already
  // had a bad line" flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= SEARCH;
      good_cnt <= '0;
      bad_seen <= 1'b0;
    end else begin
      state    <= state_next;
      good_cnt <= good_cnt_next;
      bad_seen <= bad_seen_next;
    end
  end

  assign good_cnt_inc = good_cnt + CNT_W'(1);

  // Lock FSM next state. In CHECK a bad line clears the count immediately
  // and also poisons the frame it belongs to, so the closing FS cannot count
  // it as good. Only LOCKED raises err.
  always_comb begin
    state_next    = state;
    good_cnt_next = good_cnt;
    bad_seen_next = bad_seen;
    err_int       = 1'b0;
    if (fs)
      bad_seen_next = 1'b0;
    case (state)
      SEARCH: begin
        if (fs) begin
          state_next    = CHECK;
          good_cnt_next = '0;
        end
      end
      CHECK: begin
        if (line_bad) begin
          good_cnt_next = '0;
          if (!fs)
            bad_seen_next = 1'b1;
        end
        if (fs) begin
          if (frame_ok && !bad_seen && !line_bad) begin
            if (good_cnt_inc == LOCK_W) begin
              state_next    = LOCKED;
              good_cnt_next = '0;
            end else begin
              good_cnt_next = good_cnt_inc;
            end
          end else begin
            good_cnt_next = '0;
          end
        end
      end
      LOCKED: begin
        if (line_bad || (fs && !frame_ok) || h_sat) begin
          err_int    = 1'b1;
          state_next = SEARCH;
        end
      end
      default: begin
        state_next    = SEARCH;
        good_cnt_next = '0;
      end
    endcase
  end

  assign locked      = (state == LOCKED);
  assign frame_start = fs;
  assign err         = err_int;

`ifdef VGA_DEC_ERRCNT_EN
  logic [7:0] err_cnt_q;

  // Error counter, saturating at 255; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_cnt_q <= '0;
    else if (err_int && (err_cnt_q != 8'hFF))
      err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = 8'd0;
`endif

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have parameters (name, default, meaning): H_TOTAL 800 pixel clocks per line; V_TOTAL 525 lines per frame; LOCK_FRAMES 2 consecutive good frames to lock.
REQ-002 SHALL have clk input 1: 25 MHz pixel clock, one pixel per cycle, all logic on its rising edge.
REQ-003 SHALL have reset input 1: asynchronous, active-high reset.
REQ-004 SHALL have sync_h input 1: horizontal sync, active-low pulse.
REQ-005 SHALL have sync_v input 1: vertical sync, active-low pulse.
REQ-006 SHALL have blank_n input 1: high during active video.
REQ-007 SHALL have col_o output 10: active-pixel column of the current pixel.
REQ-008 SHALL have row_o output 10: active-line row of the current pixel.
REQ-009 SHALL have pix_valid output 1: col_o/row_o address a displayable pixel.
REQ-010 SHALL have frame_start output 1: one-cycle pulse at each sync_v falling edge.
REQ-011 SHALL have locked output 1: timing matches H_TOTAL/V_TOTAL.
REQ-012 SHALL have err output 1: one-cycle pulse on timing violation.
REQ-013 SHALL have err_cnt_o output 8: saturating error count (see Configuration).

Function
REQ-014 SHALL register sync_h, sync_v, blank_n once (s_h, s_v, s_b); all decoding uses only the registered copies.
REQ-015 SHALL detect falling edges of s_h (line start, LS) and s_v (frame start, FS) against a second delayed copy.
REQ-016 SHALL count cycles since last LS in h_cnt (11 bits, saturating at 2047); on LS, the line length is h_cnt+1 and h_cnt reloads 0.
REQ-017 SHALL count LS events since last FS in v_cnt (10 bits, saturating at 1023); on FS, the frame length is v_cnt and v_cnt reloads 0.
REQ-018 SHALL clear the column counter on LS and increment it on each cycle with s_b=1; col_o saturates at 1023.
REQ-019 SHALL clear the row counter on FS and increment it on each s_b falling edge; row_o saturates at 1023.
REQ-020 SHALL drive pix_valid = s_b AND locked, aligned with col_o/row_o, i.e. 2 clk after blank_n at the pins.
REQ-021 SHALL implement FSM SEARCH -> CHECK -> LOCKED; locked=1 only in LOCKED.
REQ-022 SEARCH: on first FS, go CHECK with good-frame count 0.
REQ-023 CHECK: a frame is good when every LS in it gives line length H_TOTAL and the FS gives frame length V_TOTAL; on a good FS, increment count; reaching LOCK_FRAMES goes LOCKED on that FS.
REQ-024 CHECK: a bad line or bad frame clears the count and stays in CHECK, with no err pulse.
REQ-025 LOCKED: a bad line length, bad frame length, or h_cnt reaching 2047 (sync lost) pulses err once and goes SEARCH; locked falls the next cycle.
REQ-026 On simultaneous LS and FS in one cycle, SHALL evaluate the line-length check before the frame-length check, and SHALL count the LS in the terminating frame.
REQ-027 SHALL pulse frame_start on every FS in any state.

Reset
REQ-028 While reset=1, SHALL force FSM=SEARCH, all counters and synchronizer flops to 0, and col_o=0, row_o=0, pix_valid=0, frame_start=0, locked=0, err=0, err_cnt_o=0.
REQ-029 Reset asserted mid-frame SHALL take effect immediately; after release, the first FS restarts lock acquisition, and no err is raised for the partial frame.

Configuration
REQ-030 With VGA_DEC_ERRCNT_EN defined, err_cnt_o SHALL increment on each err pulse, saturate at 255, and clear only on reset.
REQ-031 Without VGA_DEC_ERRCNT_EN, err_cnt_o SHALL be constant 0 and contain no counter logic.

Verification
REQ-032 Standard 640x480 stimulus (800x525) from reset -> locked rises exactly on the 3rd FS; err never pulses.
REQ-033 Locked; first active pixel of line 0 -> pix_valid=1 with col_o=0, row_o=0; last active pixel -> col_o=639, row_o=479.
REQ-034 Locked; one line shortened to 799 clocks -> single err pulse, locked=0 next cycle, relock after 2 further good frames, err_cnt_o=1 with macro.
REQ-035 Locked; sync_h held high for 2100 cycles -> err when h_cnt reaches 2047, FSM in SEARCH.
REQ-036 Frame of 524 lines during CHECK -> no err, count cleared, locked delayed by one extra frame.
REQ-037 Reset pulsed at line 200 while locked -> all outputs 0 immediately; locked returns on the 3rd FS after release.
